// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses SYNC/LEN/payload[/CHK] frames and writes the payload to instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to enable the trailing checksum byte and the ERR state.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_DONE = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd5;
`endif

    localparam logic [DATA_W-1:0] SYNC = 8'hA5;

    logic [2:0]        state;
    logic [DATA_W:0]   remain;
    logic [ADDR_W-1:0] addr_cnt;
    logic              xfer;

    assign in_ready = (state != S_DONE);
    assign done     = (state == S_DONE);
    assign cpu_hold = (state != S_DONE);
    assign xfer     = in_valid && in_ready;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;

    // Frame is good when the wrapped payload sum plus the checksum byte is zero.
    function automatic logic chk_pass(input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] c);
        logic [DATA_W-1:0] t;
        t = s + c;
        return (t == '0);
    endfunction

    assign error = (state == S_ERR);
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            remain   <= '0;
            addr_cnt <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (xfer) begin
                case (state)
                    S_IDLE: begin
                        if (in_data == SYNC) state <= S_LEN;
                    end
                    S_LEN: begin
                        // A zero length byte encodes a full 256-byte payload.
                        remain   <= (in_data == '0) ? {1'b1, {DATA_W{1'b0}}} : {1'b0, in_data};
                        addr_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum      <= '0;
`endif
                        state    <= S_DATA;
                    end
                    S_DATA: begin
                        // stage boundary: write port registered one cycle after the transfer
                        wr_en    <= 1'b1;
                        wr_addr  <= addr_cnt;
                        wr_data  <= in_data;
                        addr_cnt <= addr_cnt + 1'b1;
                        remain   <= remain - 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum      <= sum + in_data;
                        if (remain == {{DATA_W{1'b0}}, 1'b1}) state <= S_CHK;
`else
                        if (remain == {{DATA_W{1'b0}}, 1'b1}) state <= S_DONE;
`endif
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_CHK: begin
                        state <= chk_pass(sum, in_data) ? S_DONE : S_ERR;
                    end
                    S_ERR: begin
                        if (in_data == SYNC) state <= S_LEN;
                    end
`endif
                    S_DONE: begin
                        state <= S_DONE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
